id_stage: RTL
=============

# id_stage

Instruction-decode stage of the five-stage pipeline. Sits between the IF/ID latch and EX. It:
- drives the register-file read addresses and reads operands the same cycle;
- bypasses the same-cycle writeback into those operands;
- decodes control;
- detects load-use hazards;
- owns the ID/EX pipeline register, including its stall, bubble and flush behaviour.

## Interface

Parameters:
- DW, 32, data/PC width
- AW, 5, register address width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; asynchronous assert, active-low
- if_valid  in  1  IF/ID holds a valid instruction
- if_instr  in  DW  instruction word
- if_pc  in  DW  PC of if_instr
- ex_hold  in  1  EX cannot accept; ID/EX must hold
- flush  in  1  branch-taken squash from EX
- stall  out  1  IF must hold if_instr/if_pc this cycle
- rf_ra1, rf_ra2  out  AW  register-file read addresses (instr[25:21], instr[20:16])
- rf_rd1, rf_rd2  in  DW  register-file read data (combinational)
- wb_we, wb_wa, wb_wd  in  1/AW/DW  writeback port, also driven into register file
- idex_valid  out  1  ID/EX slot valid
- idex_pc, idex_a, idex_b, idex_imm  out  DW  PC, operand A (rs), operand B (rt), sign-extended instr[15:0]
- idex_rs, idex_rt, idex_dst  out  AW  source and destination register numbers
- idex_regwrite, idex_memread, idex_memwrite, idex_alusrc, idex_branch  out  1  control bits
- idex_aluop  out  4  ALU operation

## Operation

Decode, keyed on opcode = instr[31:26]:
- 0x00 R-type: dst = instr[15:11], uses rs and rt.
  - funct 0x20 → aluop 0; 0x22 → 1; 0x24 → 2; 0x25 → 3; 0x2A → 4.
  - Any other funct: aluop 0xF, regwrite 0.
- 0x08 addi: dst = rt, alusrc 1, aluop 0, uses rs.
- 0x23 lw: dst = rt, memread 1, alusrc 1, aluop 0, uses rs.
- 0x2B sw: memwrite 1, alusrc 1, aluop 0, uses rs and rt.
- 0x04 beq: branch 1, aluop 1, uses rs and rt.
- Any other opcode: all control bits 0, aluop 0, uses nothing.
- regwrite is forced to 0 when dst = 0.

Operand selection, evaluated per source:
- Address 0 → 0. Register 0 is not guaranteed to read 0 from the register file.
- Else if wb_we and wb_wa equals the address → wb_wd (WB bypass).
- Else rf_rd.

Load-use hazard (lu) is true when all of the following hold:
- idex_valid and idex_memread;
- idex_dst != 0;
- if_valid;
- a used source equals idex_dst.

Combinational outputs:
- stall = (lu | ex_hold) & ~flush.

ID/EX update at each rising edge, highest priority first:
1. flush: idex_valid ← 0 and all control bits ← 0. Data fields are don't-care.
2. ex_hold: all ID/EX fields hold.
3. lu: insert bubble (idex_valid ← 0, control ← 0). The instruction stays in IF/ID.
4. Otherwise: load decoded instruction. idex_valid ← if_valid; control is zeroed if !if_valid.

## Timing

- Reset (rst_n low, asynchronous): all idex_* outputs 0, therefore stall = 0. Reset mid-operation discards the ID/EX content immediately, without waiting for a clock edge.
- Decode-to-ID/EX latency: 1 cycle. Register-file read, bypass and decode are combinational within the cycle.
- A load followed directly by a dependent instruction costs exactly one bubble cycle. The next cycle, the load sits in EX/MEM, not ID/EX, so no further stall.
- A write at edge N is visible to a decode in the same cycle before edge N via bypass.
- flush and lu in the same cycle: flush wins and stall = 0. IF redirects.
- ex_hold and lu in the same cycle: hold wins. lu is re-evaluated every cycle.
- rf_ra1/rf_ra2 follow if_instr combinationally, even when if_valid = 0.

## Configuration

- ID_WB_BYPASS_EN defined: WB bypass as described above.
- ID_WB_BYPASS_EN undefined: no bypass; operands come straight from rf_rd, with register 0 still forced to 0. Instead:
  - the hazard term is extended to: wb_we & wb_wa != 0 & (wb_wa == a used source);
  - this term is OR'ed into lu, costing one bubble;
  - results are architecturally identical, only the timing differs.

## Test plan

- Reset: rst_n low mid-stream with idex_valid = 1 → all idex_* = 0 and stall = 0 immediately, before the next clock edge.
- Decode: addi r3,r1,-4 (0x2023FFFC) with r1 = 10 → after 1 edge:
  - idex_a = 10, idex_imm = 0xFFFFFFFC, idex_dst = 3;
  - idex_regwrite = 1, idex_alusrc = 1, idex_aluop = 0.
- Load-use: lw r2,0(r1) then add r4,r2,r2:
  - after the load edge, stall = 1 for one cycle;
  - idex_valid = 0 for one cycle;
  - then add enters ID/EX with idex_dst = 4.
- Bypass:
  - with the macro defined: wb_we = 1, wb_wa = 5, wb_wd = 0x1234 while decoding or r6,r5,r0 → idex_a = 0x1234, no stall;
  - with the macro undefined: one bubble, then idex_a = 0x1234 read from the register file.
- Priority: flush and lu together → stall = 0 and idex_valid = 0 next edge. ex_hold alone for 3 cycles → ID/EX unchanged and stall = 1 throughout.
- r0 handling: add r0,r1,r2 → idex_regwrite = 0. A source of r0 with the register file returning 0xDEAD → operand = 0.

Source files
------------

// File: rtl/id_stage_if.sv
// Signal bundle of the decode stage: IF/ID input, register-file read and writeback
// ports, and the ID/EX register outputs. The decode stage sits on the slave side.
interface id_stage_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic          if_valid;
  logic [DW-1:0] if_instr;
  logic [DW-1:0] if_pc;
  logic          ex_hold;
  logic          flush;
  logic          stall;
  logic [AW-1:0] rf_ra1;
  logic [AW-1:0] rf_ra2;
  logic [DW-1:0] rf_rd1;
  logic [DW-1:0] rf_rd2;
  logic          wb_we;
  logic [AW-1:0] wb_wa;
  logic [DW-1:0] wb_wd;
  logic          idex_valid;
  logic [DW-1:0] idex_pc;
  logic [DW-1:0] idex_a;
  logic [DW-1:0] idex_b;
  logic [DW-1:0] idex_imm;
  logic [AW-1:0] idex_rs;
  logic [AW-1:0] idex_rt;
  logic [AW-1:0] idex_dst;
  logic          idex_regwrite;
  logic          idex_memread;
  logic          idex_memwrite;
  logic          idex_alusrc;
  logic          idex_branch;
  logic [3:0]    idex_aluop;

  modport master (
    output if_valid, if_instr, if_pc, ex_hold, flush,
    output rf_rd1, rf_rd2, wb_we, wb_wa, wb_wd,
    input  stall, rf_ra1, rf_ra2,
    input  idex_valid, idex_pc, idex_a, idex_b, idex_imm,
    input  idex_rs, idex_rt, idex_dst,
    input  idex_regwrite, idex_memread, idex_memwrite, idex_alusrc, idex_branch, idex_aluop
  );

  modport slave (
    input  if_valid, if_instr, if_pc, ex_hold, flush,
    input  rf_rd1, rf_rd2, wb_we, wb_wa, wb_wd,
    output stall, rf_ra1, rf_ra2,
    output idex_valid, idex_pc, idex_a, idex_b, idex_imm,
    output idex_rs, idex_rt, idex_dst,
    output idex_regwrite, idex_memread, idex_memwrite, idex_alusrc, idex_branch, idex_aluop
  );
endinterface

// File: rtl/id_stage.sv
// Decode stage: register read with WB bypass, control decode, load-use detection and
// the ID/EX register. Define ID_WB_BYPASS_EN to bypass WB; otherwise a WB hazard stalls.
module id_stage #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic      clk,
  input  logic      rst_n,
  id_stage_if.slave bus
);

  typedef struct packed {
    logic          valid;
    logic [DW-1:0] pc;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] imm;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic [AW-1:0] dst;
    logic          regwrite;
    logic          memread;
    logic          memwrite;
    logic          alusrc;
    logic          branch;
    logic [3:0]    aluop;
  } idex_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  idex_t idex_q, idex_d;

  logic [5:0]    opcode, funct;
  logic [AW-1:0] rs, rt, rd;
  logic [DW-1:0] imm_sext;

  assign opcode   = bus.if_instr[31:26];
  assign funct    = bus.if_instr[5:0];
  assign rs       = AW'(bus.if_instr[25:21]);
  assign rt       = AW'(bus.if_instr[20:16]);
  assign rd       = AW'(bus.if_instr[15:11]);
  assign imm_sext = {{(DW-16){bus.if_instr[15]}}, bus.if_instr[15:0]};

  assign bus.rf_ra1 = rs;
  assign bus.rf_ra2 = rt;

  logic          dec_use_rs, dec_use_rt, dec_rw_raw, dec_regwrite;
  logic          dec_memread, dec_memwrite, dec_alusrc, dec_branch;
  logic [3:0]    dec_aluop;
  logic [AW-1:0] dec_dst;

  always_comb begin
    dec_use_rs   = 1'b0;
    dec_use_rt   = 1'b0;
    dec_rw_raw   = 1'b0;
    dec_memread  = 1'b0;
    dec_memwrite = 1'b0;
    dec_alusrc   = 1'b0;
    dec_branch   = 1'b0;
    dec_aluop    = 4'h0;
    dec_dst      = '0;
    case (opcode)
      OP_RTYPE: begin
        dec_use_rs = 1'b1;
        dec_use_rt = 1'b1;
        dec_dst    = rd;
        dec_rw_raw = 1'b1;
        case (funct)
          6'h20:   dec_aluop = 4'h0;
          6'h22:   dec_aluop = 4'h1;
          6'h24:   dec_aluop = 4'h2;
          6'h25:   dec_aluop = 4'h3;
          6'h2A:   dec_aluop = 4'h4;
          default: begin
            dec_aluop  = 4'hF;
            dec_rw_raw = 1'b0;
          end
        endcase
      end
      OP_ADDI: begin
        dec_use_rs = 1'b1;
        dec_dst    = rt;
        dec_rw_raw = 1'b1;
        dec_alusrc = 1'b1;
      end
      OP_LW: begin
        dec_use_rs  = 1'b1;
        dec_dst     = rt;
        dec_rw_raw  = 1'b1;
        dec_memread = 1'b1;
        dec_alusrc  = 1'b1;
      end
      OP_SW: begin
        dec_use_rs   = 1'b1;
        dec_use_rt   = 1'b1;
        dec_memwrite = 1'b1;
        dec_alusrc   = 1'b1;
      end
      OP_BEQ: begin
        dec_use_rs = 1'b1;
        dec_use_rt = 1'b1;
        dec_branch = 1'b1;
        dec_aluop  = 4'h1;
      end
      default: ;
    endcase
  end

  // Writes to r0 are architecturally discarded, so never advertise them downstream.
  assign dec_regwrite = dec_rw_raw && (dec_dst != '0);

  logic          byp1, byp2, wb_hit;
  logic [DW-1:0] op_a, op_b;

`ifdef ID_WB_BYPASS_EN
  assign byp1   = bus.wb_we && (bus.wb_wa == rs);
  assign byp2   = bus.wb_we && (bus.wb_wa == rt);
  assign wb_hit = 1'b0;
`else
  assign byp1   = 1'b0;
  assign byp2   = 1'b0;
  assign wb_hit = bus.if_valid && bus.wb_we && (bus.wb_wa != '0) &&
                  ((dec_use_rs && (rs == bus.wb_wa)) || (dec_use_rt && (rt == bus.wb_wa)));
`endif

  // The register file may return garbage for r0, so zero it here.
  assign op_a = (rs == '0) ? '0 : (byp1 ? bus.wb_wd : bus.rf_rd1);
  assign op_b = (rt == '0) ? '0 : (byp2 ? bus.wb_wd : bus.rf_rd2);

  logic src_hit, lu_load, lu;

  assign src_hit = (dec_use_rs && (rs == idex_q.dst)) || (dec_use_rt && (rt == idex_q.dst));
  assign lu_load = idex_q.valid && idex_q.memread && (idex_q.dst != '0) &&
                   bus.if_valid && src_hit;
  assign lu      = lu_load || wb_hit;

  assign bus.stall = (lu || bus.ex_hold) && !bus.flush;

  function automatic idex_t squash(idex_t x);
    idex_t y = x;
    y.valid    = 1'b0;
    y.regwrite = 1'b0;
    y.memread  = 1'b0;
    y.memwrite = 1'b0;
    y.alusrc   = 1'b0;
    y.branch   = 1'b0;
    y.aluop    = 4'h0;
    return y;
  endfunction

  always_comb begin
    idex_d = idex_q;
    if (bus.flush) begin
      idex_d = squash(idex_q);
    end else if (bus.ex_hold) begin
      idex_d = idex_q;
    end else if (lu) begin
      idex_d = squash(idex_q);
    end else begin
      idex_d.valid    = bus.if_valid;
      idex_d.pc       = bus.if_pc;
      idex_d.a        = op_a;
      idex_d.b        = op_b;
      idex_d.imm      = imm_sext;
      idex_d.rs       = rs;
      idex_d.rt       = rt;
      idex_d.dst      = dec_dst;
      idex_d.regwrite = dec_regwrite;
      idex_d.memread  = dec_memread;
      idex_d.memwrite = dec_memwrite;
      idex_d.alusrc   = dec_alusrc;
      idex_d.branch   = dec_branch;
      idex_d.aluop    = dec_aluop;
      if (!bus.if_valid) idex_d = squash(idex_d);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idex_q <= '0;
    else        idex_q <= idex_d;
  end

  assign bus.idex_valid    = idex_q.valid;
  assign bus.idex_pc       = idex_q.pc;
  assign bus.idex_a        = idex_q.a;
  assign bus.idex_b        = idex_q.b;
  assign bus.idex_imm      = idex_q.imm;
  assign bus.idex_rs       = idex_q.rs;
  assign bus.idex_rt       = idex_q.rt;
  assign bus.idex_dst      = idex_q.dst;
  assign bus.idex_regwrite = idex_q.regwrite;
  assign bus.idex_memread  = idex_q.memread;
  assign bus.idex_memwrite = idex_q.memwrite;
  assign bus.idex_alusrc   = idex_q.alusrc;
  assign bus.idex_branch   = idex_q.branch;
  assign bus.idex_aluop    = idex_q.aluop;

endmodule
